// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side request ports and the shared memory bus seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding CPU/memory view.
interface mem_arbiter_if;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_ack;

  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_ack;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  logic        stall;
  logic        timeout;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteenable,
           m_readdata, m_waitrequest,
    output i_readdata, i_ack, d_readdata, d_ack, m_address, m_read, m_write,
           m_writedata, m_byteenable, stall, timeout
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteenable,
           m_readdata, m_waitrequest,
    input  i_readdata, i_ack, d_readdata, d_ack, m_address, m_read, m_write,
           m_writedata, m_byteenable, stall, timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one waitrequest-style memory bus,
// one registered transaction at a time, with a watchdog that aborts stuck transfers.
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic             last_d;
  logic [CNT_W-1:0] wait_cnt;

  logic elig_i;
  logic elig_d;
  logic pick_i;
  logic pick_d;
  logic done;
  logic abort;

  // A port whose ack is high this cycle is retiring, so it must not be granted again.
  assign elig_i = bus.i_read & ~bus.i_ack;
  assign elig_d = (bus.d_read | bus.d_write) & ~bus.d_ack;
  assign pick_d = elig_d & (~elig_i | (ROUND_ROBIN == 0) | ~last_d);
  assign pick_i = elig_i & ~pick_d;

  assign done  = ~bus.m_waitrequest;
  assign abort = (TIMEOUT != 0) && bus.m_waitrequest && (wait_cnt == CNT_MAX);

  assign bus.stall = elig_i | elig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_d           <= 1'b0;
      wait_cnt         <= '0;
      bus.m_address    <= '0;
      bus.m_read       <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_writedata  <= '0;
      bus.m_byteenable <= '0;
      bus.i_ack        <= 1'b0;
      bus.d_ack        <= 1'b0;
      bus.i_readdata   <= '0;
      bus.d_readdata   <= '0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state            <= GNT_D;
            bus.m_address    <= bus.d_address;
            bus.m_writedata  <= bus.d_writedata;
            bus.m_byteenable <= bus.d_byteenable;
            bus.m_read       <= bus.d_read;
            bus.m_write      <= bus.d_write;
            wait_cnt         <= '0;
          end else if (pick_i) begin
            state            <= GNT_I;
            bus.m_address    <= bus.i_address;
            bus.m_writedata  <= '0;
            bus.m_byteenable <= 4'hF;
            bus.m_read       <= 1'b1;
            bus.m_write      <= 1'b0;
            wait_cnt         <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (done || abort) begin
            // An aborted read returns zero rather than whatever is on m_readdata.
            state       <= IDLE;
            last_d      <= (state == GNT_D);
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            if (abort) bus.timeout <= 1'b1;
            if (state == GNT_I) begin
              bus.i_ack <= 1'b1;
              if (bus.m_read) bus.i_readdata <= abort ? 32'h0 : bus.m_readdata;
            end else begin
              bus.d_ack <= 1'b1;
              if (bus.m_read) bus.d_readdata <= abort ? 32'h0 : bus.m_readdata;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter: a round-robin and a fixed-priority
// instance share stimulus and are compared against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] rdata;
  logic        m_waitrequest;
  int          wait_cfg;
  int          wcnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        last_d_rr;
  logic [31:0] exp_ird;
  logic [31:0] exp_drd;
  logic        exp_to;

  always #5 clk = ~clk;

  mem_arbiter_if ba ();
  mem_arbiter_if bb ();

  assign ba.i_read = i_read;           assign bb.i_read = i_read;
  assign ba.i_address = i_address;     assign bb.i_address = i_address;
  assign ba.d_read = d_read;           assign bb.d_read = d_read;
  assign ba.d_write = d_write;         assign bb.d_write = d_write;
  assign ba.d_address = d_address;     assign bb.d_address = d_address;
  assign ba.d_writedata = d_writedata; assign bb.d_writedata = d_writedata;
  assign ba.d_byteenable = d_byteenable; assign bb.d_byteenable = d_byteenable;
  assign ba.m_readdata = rdata;        assign bb.m_readdata = rdata;
  assign ba.m_waitrequest = m_waitrequest; assign bb.m_waitrequest = m_waitrequest;

  // Memory model: hold waitrequest for wait_cfg strobe cycles, then complete.
  assign m_waitrequest = (wcnt < wait_cfg);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if ((!ba.m_read && !ba.m_write) || !m_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TO)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(ba));
  mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TO)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] ga, input logic [31:0] gb,
                      input logic [31:0] e);
    chk({tag, "/rr"}, ga, e);
    chk({tag, "/fp"}, gb, e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk2({tag, " m_read"}, 32'(ba.m_read), 32'(bb.m_read), 32'h0);
    chk2({tag, " m_write"}, 32'(ba.m_write), 32'(bb.m_write), 32'h0);
    chk2({tag, " m_address"}, ba.m_address, bb.m_address, 32'h0);
    chk2({tag, " m_writedata"}, ba.m_writedata, bb.m_writedata, 32'h0);
    chk2({tag, " m_byteenable"}, 32'(ba.m_byteenable), 32'(bb.m_byteenable), 32'h0);
    chk2({tag, " acks"}, 32'({ba.i_ack, ba.d_ack}), 32'({bb.i_ack, bb.d_ack}), 32'h0);
    chk2({tag, " i_readdata"}, ba.i_readdata, bb.i_readdata, 32'h0);
    chk2({tag, " d_readdata"}, ba.d_readdata, bb.d_readdata, 32'h0);
    chk2({tag, " timeout"}, 32'(ba.timeout), 32'(bb.timeout), 32'h0);
  endtask

  // One single-port transaction; the model predicts latency, bus contents and results.
  task automatic txn(input bit is_d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int waits,
                     input logic [31:0] rd);
    bit ab;
    int ack_c;
    ab    = (waits > TO);
    ack_c = ab ? TO + 2 : waits + 2;
    wait_cfg = waits;
    rdata    = rd;
    if (is_d) begin
      d_read = !wr; d_write = wr; d_address = addr; d_writedata = wdata; d_byteenable = be;
    end else begin
      i_read = 1'b1; i_address = addr;
    end
    for (int c = 1; c <= ack_c; c++) begin
      step();
      if (c < ack_c) begin
        chk2("m_read", 32'(ba.m_read), 32'(bb.m_read), 32'(!wr));
        chk2("m_write", 32'(ba.m_write), 32'(bb.m_write), 32'(wr));
        chk2("m_address", ba.m_address, bb.m_address, addr);
        chk2("m_byteenable", 32'(ba.m_byteenable), 32'(bb.m_byteenable), is_d ? 32'(be) : 32'hF);
        if (wr) chk2("m_writedata", ba.m_writedata, bb.m_writedata, wdata);
        chk2("early_ack", 32'({ba.i_ack, ba.d_ack}), 32'({bb.i_ack, bb.d_ack}), 32'h0);
        chk2("stall_busy", 32'(ba.stall), 32'(bb.stall), 32'h1);
      end else begin
        if (!wr) begin
          if (is_d) exp_drd = ab ? 32'h0 : rd;
          else      exp_ird = ab ? 32'h0 : rd;
        end
        if (ab) exp_to = 1'b1;
        last_d_rr = is_d;
        chk2("i_ack", 32'(ba.i_ack), 32'(bb.i_ack), 32'(!is_d));
        chk2("d_ack", 32'(ba.d_ack), 32'(bb.d_ack), 32'(is_d));
        chk2("strobe_off", 32'({ba.m_read, ba.m_write}), 32'({bb.m_read, bb.m_write}), 32'h0);
        chk2("i_readdata", ba.i_readdata, bb.i_readdata, exp_ird);
        chk2("d_readdata", ba.d_readdata, bb.d_readdata, exp_drd);
        chk2("timeout", 32'(ba.timeout), 32'(bb.timeout), 32'(exp_to));
        chk2("stall_ack", 32'(ba.stall), 32'(bb.stall), 32'h0);
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; wait_cfg = 0;
    step();
    chk2("no_dup", 32'({ba.m_read, ba.m_write, ba.i_ack, ba.d_ack}),
         32'({bb.m_read, bb.m_write, bb.i_ack, bb.d_ack}), 32'h0);
    chk2("stall_idle", 32'(ba.stall), 32'(bb.stall), 32'h0);
  endtask

  // Both ports request in the same cycle; round-robin winner depends on the last grant.
  task automatic tie_round(input logic [31:0] rd);
    logic rr_d;
    rr_d = !last_d_rr;
    wait_cfg = 0;
    rdata = rd;
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000; d_byteenable = 4'hF;
    step();
    chk("tie first/rr", ba.m_address, rr_d ? 32'h0000_2000 : 32'h0000_1000);
    chk("tie first/fp", bb.m_address, 32'h0000_2000);
    step();
    chk("tie ack1 d/rr", 32'(ba.d_ack), 32'(rr_d));
    chk("tie ack1 i/rr", 32'(ba.i_ack), 32'(!rr_d));
    chk("tie ack1/fp", 32'({bb.i_ack, bb.d_ack}), 32'b01);
    step();
    chk("tie second/rr", ba.m_address, rr_d ? 32'h0000_1000 : 32'h0000_2000);
    chk("tie second/fp", bb.m_address, 32'h0000_1000);
    chk2("tie ack gap", 32'({ba.i_ack, ba.d_ack}), 32'({bb.i_ack, bb.d_ack}), 32'h0);
    i_read = 1'b0; d_read = 1'b0;
    step();
    chk("tie ack2/rr", 32'({ba.i_ack, ba.d_ack}), rr_d ? 32'b10 : 32'b01);
    chk("tie ack2/fp", 32'({bb.i_ack, bb.d_ack}), 32'b10);
    last_d_rr = !rr_d;
    exp_ird = rd;
    exp_drd = rd;
    chk2("tie i_readdata", ba.i_readdata, bb.i_readdata, exp_ird);
    chk2("tie d_readdata", ba.d_readdata, bb.d_readdata, exp_drd);
    step();
    chk2("tie idle", 32'({ba.m_read, ba.i_ack, ba.d_ack}), 32'({bb.m_read, bb.i_ack, bb.d_ack}), 32'h0);
  endtask

  initial begin
    logic        r_d;
    logic        r_wr;
    logic [31:0] r_a;
    logic [31:0] r_w;
    logic [3:0]  r_be;
    int          r_wt;
    logic [31:0] r_rd;

    rst_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_writedata = '0; d_byteenable = '0; rdata = '0; wait_cfg = 0;
    last_d_rr = 1'b0; exp_ird = '0; exp_drd = '0; exp_to = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    chk2("reset stall", 32'(ba.stall), 32'(bb.stall), 32'h0);
    rst_n = 1'b1;
    step();

    txn(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, 0, 32'h2402_0005);
    txn(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 3, 32'h5555_AAAA);

    tie_round(32'h0BAD_F00D);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 32'h1111_2222);
    tie_round(32'hCAFE_0001);
    txn(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 2, 32'h3333_4444);
    tie_round(32'hCAFE_0002);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        tie_round($urandom);
      end else begin
        r_d  = 1'($urandom_range(0, 1));
        r_wr = r_d & 1'($urandom_range(0, 1));
        r_a  = $urandom;
        r_w  = $urandom;
        r_be = 4'($urandom_range(0, 15));
        r_wt = $urandom_range(0, 3);
        r_rd = $urandom;
        txn(r_d, r_wr, r_a, r_w, r_be, r_wt, r_rd);
      end
    end

    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 99, 32'h1234_5678);
    txn(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'hC, 1, 32'h0);
    txn(1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, 0, 32'h7777_8888);

    i_read = 1'b1; i_address = 32'h0000_0800; wait_cfg = 99; rdata = 32'h9999_0000;
    step();
    chk2("pre-rst strobe", 32'(ba.m_read), 32'(bb.m_read), 32'h1);
    step();
    chk2("pre-rst hold", 32'(ba.m_read), 32'(bb.m_read), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    exp_to = 1'b0; exp_ird = '0; exp_drd = '0; last_d_rr = 1'b0;
    chk_idle_outputs("async rst");
    step();
    step();
    chk2("in rst no ack", 32'({ba.i_ack, ba.m_read}), 32'({bb.i_ack, bb.m_read}), 32'h0);
    wait_cfg = 0;
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, 32'h9999_0001);
    tie_round(32'hFEED_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
